muldiv_ctrl: RTL and testbench

Sequencer for the RV32M execute slot. Accepts one M-extension operation per valid/ready handshake, drives the combinational `multiplier` block as a multicycle path, and runs an internal iterative radix-2 divider for DIV/DIVU/REM/REMU. Returns one tagged 32-bit result per request through a valid/ready response port. Sits between the decode/issue stage and the writeback arbiter.

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_ctrl_div_iter.sv | 88 ++++++++
 rtl/multiplier.sv | 34 +++
 rtl/muldiv_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared encodings and constants for the RV32M multiply/divide sequencer.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  // funct3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DIV_ITERS = 32;

  // Divide-by-zero quotient and signed-overflow quotient
  localparam logic [31:0] C_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] C_INT_MIN  = 32'h8000_0000;

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_div_iter.sv
// ----------------------------------------------------------------------------
// div_iter
// Radix-2 restoring divider on operand magnitudes, one quotient bit per
// cycle MSB first. o_done marks the cycle of the last iteration; o_quot and
// o_rem already carry the sign fix during that cycle.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_start,
  input  logic        i_kill,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_done,
  output logic [31:0] o_quot,
  output logic [31:0] o_rem
);

  logic        r_active;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [31:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;

  logic        w_a_neg;
  logic        w_b_neg;
  logic [32:0] w_trial;
  logic        w_ge;
  logic [31:0] w_rem_n;
  logic [31:0] w_quot_n;

  assign w_a_neg = i_signed & i_dividend[31];
  assign w_b_neg = i_signed & i_divisor[31];

  // Partial remainder shifted left with the next dividend bit brought in;
  // the result of a successful subtract is always below the divisor, so the
  // low 32 bits of the difference are exact.
  assign w_trial  = {r_rem, r_quot[31]};
  assign w_ge     = (w_trial >= {1'b0, r_dvs});
  assign w_rem_n  = w_ge ? (w_trial[31:0] - r_dvs) : w_trial[31:0];
  assign w_quot_n = {r_quot[30:0], w_ge};

  assign o_done = r_active && (r_cnt == 5'(DIV_ITERS - 1));
  assign o_quot = r_neg_q ? (32'd0 - w_quot_n) : w_quot_n;
  assign o_rem  = r_neg_r ? (32'd0 - w_rem_n) : w_rem_n;

  // Load magnitudes on start, then iterate until the final bit is produced
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quot   <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_kill) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quot   <= w_a_neg ? (32'd0 - i_dividend) : i_dividend;
      r_dvs    <= w_b_neg ? (32'd0 - i_divisor) : i_divisor;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
    end else if (r_active) begin
      r_rem  <= w_rem_n;
      r_quot <= w_quot_n;
      r_cnt  <= r_cnt + 5'd1;
      if (o_done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/multiplier.sv
// ----------------------------------------------------------------------------
// multiplier
// Combinational 32x32 multiplier covering MUL/MULH/MULHSU/MULHU.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multiplier
  import muldiv_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_res
);

  logic               w_a_signed;
  logic               w_b_signed;
  logic signed [32:0] w_a;
  logic signed [32:0] w_b;
  logic signed [63:0] w_prod;

  // rs1 is signed for MULH/MULHSU, rs2 only for MULH; the low word is
  // independent of signedness so MUL may use either extension.
  assign w_a_signed = (i_op != OP_MULHU[1:0]);
  assign w_b_signed = (i_op == OP_MULH[1:0]);
  assign w_a        = {w_a_signed & i_a[31], i_a};
  assign w_b        = {w_b_signed & i_b[31], i_b};
  assign w_prod     = 64'(w_a) * 64'(w_b);
  assign o_res      = (i_op == OP_MUL[1:0]) ? w_prod[31:0] : w_prod[63:32];

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl
// RV32M execute-slot sequencer: multicycle multiply, iterative divide with a
// one-entry quotient cache, tagged valid/ready response.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [4:0]  rd_i,
  input  logic        kill_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_data_o,
  output logic [4:0]  resp_rd_o,
  output logic        busy_o
);

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [4:0]  r_rd;
  logic [2:0]  r_cnt;
  logic        r_fast;
  logic [31:0] r_fast_q;
  logic [31:0] r_fast_r;
  logic        r_cache_valid;
  logic        r_c_signed;
  logic [31:0] r_c_rs1;
  logic [31:0] r_c_rs2;
  logic [31:0] r_c_q;
  logic [31:0] r_c_r;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic [4:0]  r_resp_rd;
  logic        r_busy;

  logic        w_accept;
  logic        w_req_signed;
  logic        w_hit;
  logic        w_div0;
  logic        w_ovf;
  logic        w_div_start;
  logic [31:0] w_mul_res;
  logic        w_div_done;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;
  logic [31:0] w_fin_q;
  logic [31:0] w_fin_r;

  assign req_ready_o  = (r_state == ST_IDLE) && !kill_i && !rst_i;
  assign w_accept     = req_valid_i && req_ready_o;
  assign w_req_signed = !op_i[0];
  assign w_hit        = r_cache_valid && (r_c_signed == w_req_signed) &&
                        (r_c_rs1 == rs1_i) && (r_c_rs2 == rs2_i);
  assign w_div0       = (rs2_i == 32'd0);
  assign w_ovf        = w_req_signed && (rs1_i == C_INT_MIN) && (rs2_i == C_ALL_ONES);
  assign w_div_start  = w_accept && op_i[2] && !w_hit && !w_div0 && !w_ovf;

  // Cache hits and special cases spend one cycle in DIV with a
  // precomputed result instead of running the iterative datapath.
  assign w_fin_q = r_fast ? r_fast_q : w_div_q;
  assign w_fin_r = r_fast ? r_fast_r : w_div_r;

  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;
  assign resp_rd_o    = r_resp_rd;
  assign busy_o       = r_busy;

  multiplier u_mul (
    .i_op  (r_op),
    .i_a   (r_rs1),
    .i_b   (r_rs2),
    .o_res (w_mul_res)
  );

  div_iter u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .i_start    (w_div_start),
    .i_kill     (kill_i),
    .i_signed   (w_req_signed),
    .i_dividend (rs1_i),
    .i_divisor  (rs2_i),
    .o_done     (w_div_done),
    .o_quot     (w_div_q),
    .o_rem      (w_div_r)
  );

  // Sequencer FSM, quotient cache and registered response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_op          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_cnt         <= '0;
      r_fast        <= 1'b0;
      r_fast_q      <= '0;
      r_fast_r      <= '0;
      r_cache_valid <= 1'b0;
      r_c_signed    <= 1'b0;
      r_c_rs1       <= '0;
      r_c_rs2       <= '0;
      r_c_q         <= '0;
      r_c_r         <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_rd     <= '0;
      r_busy        <= 1'b0;
    end else if (kill_i) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_cache_valid <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= op_i[1:0];
            r_rs1  <= rs1_i;
            r_rs2  <= rs2_i;
            r_rd   <= rd_i;
            r_busy <= 1'b1;
            if (!op_i[2]) begin
              r_state <= ST_MUL;
              r_cnt   <= 3'(MUL_LATENCY - 1);
            end else begin
              r_state  <= ST_DIV;
              r_fast   <= w_hit || w_div0 || w_ovf;
              r_fast_q <= w_hit ? r_c_q : (w_div0 ? C_ALL_ONES : C_INT_MIN);
              r_fast_r <= w_hit ? r_c_r : (w_div0 ? rs1_i : 32'd0);
            end
          end
        end
        ST_MUL: begin
          if (r_cnt == 3'd0) begin
            r_resp_data  <= w_mul_res;
            r_resp_rd    <= r_rd;
            r_resp_valid <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_DIV: begin
          if (r_fast || w_div_done) begin
            r_resp_data   <= r_op[1] ? w_fin_r : w_fin_q;
            r_resp_rd     <= r_rd;
            r_resp_valid  <= 1'b1;
            r_state       <= ST_DONE;
            r_fast        <= 1'b0;
            r_cache_valid <= 1'b1;
            r_c_signed    <= !r_op[0];
            r_c_rs1       <= r_rs1;
            r_c_rs2       <= r_rs2;
            r_c_q         <= w_fin_q;
            r_c_r         <= w_fin_r;
          end
        end
        ST_DONE: begin
          if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed self-checking bench for muldiv_ctrl (MUL_LATENCY = 2).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        kill;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        busy;

  int total;
  int bad;

  muldiv_ctrl #(.MUL_LATENCY(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .op_i         (op),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .rd_i         (rd),
    .kill_i       (kill),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .resp_rd_o    (resp_rd),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure edges from accept to resp_valid, then drain it
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r,
                        input logic [31:0] exp_data, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
    @(posedge clk); #1;
    req_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0;
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " data"}, resp_data, exp_data);
    chk({tag, " rd"}, 32'(resp_rd), 32'(r));
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int seen;
    int wait_cnt;
    total = 0; bad = 0;
    rst = 1'b1; req_valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    kill = 1'b0; resp_ready = 1'b0;

    // Reset state
    #3;
    chk("rst valid", 32'(resp_valid), 32'd0);
    chk("rst data", resp_data, 32'd0);
    chk("rst rd", 32'(resp_rd), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Multiplies
    run_op("mul 7x6",       OP_MUL,    32'd7,         32'd6,         5'd3,  32'd42,        2);
    run_op("mulh -1x-1",    OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000, 2);
    run_op("mulhu -1x-1",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 2);
    run_op("mulhsu -1x2",   OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd6,  32'hFFFF_FFFF, 2);

    // Signed divides with cache reuse
    run_op("div -7/2",      OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 32);
    run_op("rem -7/2 hit",  OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 1);
    run_op("div 100/-7",    OP_DIV,    32'd100,       32'hFFFF_FFF9, 5'd12, 32'hFFFF_FFF2, 32);
    run_op("rem 100/-7 hit",OP_REM,    32'd100,       32'hFFFF_FFF9, 5'd13, 32'd2,         1);

    // Special cases
    run_op("divu 5/0",      OP_DIVU,   32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1);
    run_op("remu 5/0",      OP_REMU,   32'd5,         32'd0,         5'd15, 32'd5,         1);
    run_op("div ovf",       OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1);
    run_op("rem ovf",       OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1);

    // Warm the cache, then kill a divide: cache must be dropped
    run_op("divu 100/7",    OP_DIVU,   32'd100,       32'd7,         5'd18, 32'd14,        32);
    run_op("remu 100/7 hit",OP_REMU,   32'd100,       32'd7,         5'd19, 32'd2,         1);
    @(negedge clk);
    req_valid = 1'b1; op = OP_DIVU; rs1 = 32'd9; rs2 = 32'd4; rd = 5'd20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    #1;
    chk("kill ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill valid", 32'(resp_valid), 32'd0);
    chk("kill busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1;
    end
    chk("kill no resp", 32'(seen), 32'd0);
    run_op("divu 100/7 miss", OP_DIVU, 32'd100,       32'd7,         5'd21, 32'd14,        32);

    // Back-pressure in DONE
    @(negedge clk);
    req_valid = 1'b1; op = OP_MUL; rs1 = 32'd5; rs2 = 32'd5; rd = 5'd9;
    @(posedge clk); #1;
    req_valid = 1'b0; rs1 = '0; rs2 = '0;
    wait_cnt = 0;
    while (!resp_valid && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid", 32'(resp_valid), 32'd1);
      chk("bp data", resp_data, 32'd25);
      chk("bp rd", 32'(resp_rd), 32'd9);
      chk("bp ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("bp drain", 32'(resp_valid), 32'd0);

    // Asynchronous reset mid-multiply
    @(negedge clk);
    req_valid = 1'b1; op = OP_MUL; rs1 = 32'd3; rs2 = 32'd3; rd = 5'd22;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst valid", 32'(resp_valid), 32'd0);
    chk("arst data", resp_data, 32'd0);
    chk("arst rd", 32'(resp_rd), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1;
    end
    chk("arst discarded", 32'(seen), 32'd0);
    run_op("mul 3x4 after rst", OP_MUL, 32'd3,        32'd4,         5'd23, 32'd12,        2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
